// File: rtl/m_pkg.sv
// Shared definitions for the 1001 serial sequence detector.
package m_pkg;

  // Detector progress states; encodings 5..7 are unused and recover to S0.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // no progress
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "10"
    S3 = 3'd3,  // seen "100"
    S4 = 3'd4   // seen "1001" (match)
  } state_t;

  // Target pattern, first-received bit in the MSB.
  localparam logic [3:0] PATTERN = 4'b1001;

endpackage

// File: rtl/m_seq_detector.sv
// Moore FSM detecting the serial pattern 1,0,0,1 on x, overlapping matches allowed.
// y is a pure decode of the state register, so x has no combinational path to y.
module m_seq_detector
  import m_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x,
  output logic y
);

  state_t state_q;
  state_t state_d;

  // State register; reset overrides any transition in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; after a match the final 1 seeds the next attempt.
  always_comb begin
    state_d = S0;
    unique case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S1 : S2;
      S2:      state_d = x ? S1 : S3;
      S3:      state_d = x ? S4 : S0;
      S4:      state_d = x ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  // Moore output: high only while in the match state.
  always_comb begin
    y = (state_q == S4);
  end

endmodule

// File: tb/tb_m_seq_detector.sv
// Self-checking bench for m_seq_detector: directed vector table plus random
// stimulus compared with a sliding-window pattern model.
module tb_m_seq_detector;

  logic clk;
  logic reset;
  logic x;
  logic y;

  int n_cmp;
  int n_err;

  // Reference model: the last four bits received since reset.
  logic [3:0] hist;
  logic       exp_y;

  typedef struct {
    logic r;
    logic xv;
    logic ey;
  } vec_t;

  vec_t vecs[$];

  m_seq_detector dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bit, clock it, update the model, sample y just after the edge.
  task automatic step(input logic r, input logic xv);
    @(negedge clk);
    reset = r;
    x     = xv;
    @(posedge clk);
    if (r) hist = 4'b0000;
    else   hist = {hist[2:0], xv};
    exp_y = (hist == 4'b1001);
    #1;
  endtask

  task automatic check(input string name, input logic want);
    n_cmp++;
    if (y !== want) begin
      n_err++;
      $display("FAIL %s: y=%b expected %b (t=%0t)", name, y, want, $time);
    end
  endtask

  task automatic add(input logic r, input logic xv, input logic ey);
    vec_t v;
    v.r = r; v.xv = xv; v.ey = ey;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    hist  = 4'b0000;
    exp_y = 1'b0;
    reset = 1'b1;
    x     = 1'b0;

    // Reset for two edges with x toggling.
    add(1, 0, 0); add(1, 1, 0);
    // Basic match, then x=1 drops y.
    add(0, 1, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1); add(0, 1, 0);
    // Overlap: 1,0,0,1,0,0,1,1 -> pulses after edges 4 and 7.
    add(1, 0, 0);
    add(0, 1, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
    add(0, 0, 0); add(0, 0, 0); add(0, 1, 1); add(0, 1, 0);
    // Non-match: 1,0,1,0,0,0,1.
    add(1, 0, 0);
    add(0, 1, 0); add(0, 0, 0); add(0, 1, 0); add(0, 0, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 1, 0);
    // Mid-pattern reset (with x=1, which would otherwise complete the match).
    add(1, 0, 0);
    add(0, 1, 0); add(0, 0, 0); add(0, 0, 0);
    add(1, 1, 0);
    add(0, 1, 0); add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);
    // Leading 1s: 1,1,1,0,0,1.
    add(1, 0, 0);
    add(0, 1, 0); add(0, 1, 0); add(0, 1, 0);
    add(0, 0, 0); add(0, 0, 0); add(0, 1, 1);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].xv);
      check($sformatf("vec%0d", i), vecs[i].ey);
    end

    // Hand sequence: 1101001 matches once, at bit 7, and y lasts one cycle.
    step(1, 0);
    check("seq1101001_reset", 1'b0);
    begin
      logic [6:0] bits;
      bits = 7'b1101001;
      for (int i = 6; i >= 0; i--) begin
        step(0, bits[i]);
        check($sformatf("seq1101001_b%0d", 7 - i), (i == 0) ? 1'b1 : 1'b0);
      end
    end
    step(0, 0);
    check("seq1101001_after", 1'b0);

    // Randomized stimulus against the window model.
    step(1, 0);
    check("rand_reset", exp_y);
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic b;
      r = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 99) < 45);
      step(r, b);
      check($sformatf("rand%0d", i), exp_y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
